// File: rtl/bypass_buff_mp_if.sv
// Signal bundle for bypass_buff_mp: control, write-back, invalidate and per-port source lookup.
// The buffer takes the slave side; whatever drives the write-back and lookups takes the master side.
interface bypass_buff_mp_if #(
  parameter int unsigned BUFF_SIZE  = 8,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned WIDTH_IDX  = 8,
  parameter int unsigned WIDTH_DATA = 32
);
  localparam int unsigned NumW = $clog2(BUFF_SIZE + 1);

  logic                          stall;
  logic                          flush;
  logic                          inv_valid;
  logic [WIDTH_IDX-1:0]          inv_index;
  logic                          wb_valid;
  logic [WIDTH_IDX-1:0]          wb_index;
  logic [WIDTH_DATA-1:0]         wb_data;
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC*WIDTH_IDX-1:0]  src_index;
  logic [NUM_SRC*WIDTH_DATA-1:0] src_rf_data;
  logic [NUM_SRC*WIDTH_DATA-1:0] src_data;
  logic [NUM_SRC-1:0]            src_hit;
  logic                          full;
  logic                          empty;
  logic [NumW-1:0]               num;
  logic                          evict;

  modport master (
    output stall, flush, inv_valid, inv_index, wb_valid, wb_index, wb_data,
           src_valid, src_index, src_rf_data,
    input  src_data, src_hit, full, empty, num, evict
  );

  modport slave (
    input  stall, flush, inv_valid, inv_index, wb_valid, wb_index, wb_data,
           src_valid, src_index, src_rf_data,
    output src_data, src_hit, full, empty, num, evict
  );
endinterface

// File: rtl/bypass_buff_mp.sv
// Fully-associative bypass buffer of recent write-back results with multi-port zero-latency
// lookup, in-place update, write-back forwarding, reuse retirement and round-robin eviction.
module bypass_buff_mp #(
  parameter int unsigned BUFF_SIZE  = 8,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned WIDTH_IDX  = 8,
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned REUSE_MAX  = 0,
  parameter int unsigned FWD_WB     = 1
) (
  input logic             clock,
  input logic             reset,
  bypass_buff_mp_if.slave bus
);
  localparam int unsigned NumW = $clog2(BUFF_SIZE + 1);
  localparam int unsigned PtrW = $clog2(BUFF_SIZE);
  localparam int unsigned CntW = (REUSE_MAX > 0) ? $clog2(REUSE_MAX + 1) : 1;

  logic [BUFF_SIZE-1:0]  valid_q, valid_d;
  logic [WIDTH_IDX-1:0]  idx_q   [BUFF_SIZE];
  logic [WIDTH_DATA-1:0] data_q  [BUFF_SIZE];
  logic [CntW-1:0]       cnt_q   [BUFF_SIZE];
  logic [CntW-1:0]       cnt_upd [BUFF_SIZE];
  logic [CntW-1:0]       cnt_d   [BUFF_SIZE];
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [NumW-1:0]       num_q, num_d;
  logic                  full_q, empty_q, evict_q, evict_d;

  logic [WIDTH_IDX-1:0]          src_idx [NUM_SRC];
  logic [BUFF_SIZE-1:0]          match   [NUM_SRC];
  logic [NUM_SRC-1:0]            fwd, hit;
  logic [NUM_SRC*WIDTH_DATA-1:0] src_data;

  int unsigned          hits [BUFF_SIZE];
  int unsigned          sum  [BUFF_SIZE];
  logic [BUFF_SIZE-1:0] retire;

  logic [BUFF_SIZE-1:0] wr_match, inv_match, free_sel, wr_sel;
  logic                 wr_present, wr_en, is_full;

  always_comb begin
    logic [WIDTH_DATA-1:0] sel;
    sel      = '0;
    src_data = bus.src_rf_data;
    for (int p = 0; p < int'(NUM_SRC); p++) begin
      src_idx[p] = bus.src_index[p*WIDTH_IDX +: WIDTH_IDX];
      fwd[p]     = (FWD_WB != 0) && bus.wb_valid && bus.src_valid[p] &&
                   (bus.wb_index == src_idx[p]);
      sel        = '0;
      for (int e = 0; e < int'(BUFF_SIZE); e++) begin
        match[p][e] = bus.src_valid[p] && valid_q[e] && (idx_q[e] == src_idx[p]);
        sel         = sel | (data_q[e] & {WIDTH_DATA{match[p][e]}});
      end
      hit[p] = fwd[p] || (|match[p]);
      if (fwd[p]) begin
        src_data[p*WIDTH_DATA +: WIDTH_DATA] = bus.wb_data;
      end else if (|match[p]) begin
        src_data[p*WIDTH_DATA +: WIDTH_DATA] = sel;
      end
    end
  end

  // Forwarded hits bypass the stored entry and therefore never count toward retirement.
  always_comb begin
    for (int e = 0; e < int'(BUFF_SIZE); e++) begin
      hits[e] = 0;
      for (int p = 0; p < int'(NUM_SRC); p++) begin
        if (match[p][e] && !fwd[p]) begin
          hits[e] = hits[e] + 1;
        end
      end
      sum[e]     = hits[e] + 32'(cnt_q[e]);
      cnt_upd[e] = cnt_q[e];
      retire[e]  = 1'b0;
      if ((REUSE_MAX != 0) && !bus.stall && (hits[e] != 0)) begin
        if (sum[e] >= REUSE_MAX) begin
          cnt_upd[e] = CntW'(REUSE_MAX);
          retire[e]  = 1'b1;
        end else begin
          cnt_upd[e] = CntW'(sum[e]);
        end
      end
    end
  end

  always_comb begin
    free_sel = '0;
    for (int e = int'(BUFF_SIZE) - 1; e >= 0; e--) begin
      if (!valid_q[e]) begin
        free_sel    = '0;
        free_sel[e] = 1'b1;
      end
    end
    for (int e = 0; e < int'(BUFF_SIZE); e++) begin
      wr_match[e]  = valid_q[e] && (idx_q[e] == bus.wb_index);
      inv_match[e] = bus.inv_valid && valid_q[e] && (idx_q[e] == bus.inv_index);
    end
    wr_present = |wr_match;
    is_full    = &valid_q;
    wr_en      = bus.wb_valid && !bus.flush;
    if (wr_present) begin
      wr_sel = wr_match;
    end else if (!is_full) begin
      wr_sel = free_sel;
    end else begin
      wr_sel        = '0;
      wr_sel[ptr_q] = 1'b1;
    end
    evict_d = wr_en && !wr_present && is_full;
    ptr_d   = ptr_q;
    if (evict_d) begin
      ptr_d = (ptr_q == PtrW'(BUFF_SIZE - 1)) ? '0 : ptr_q + PtrW'(1);
    end
    // Write beats invalidate/retirement; flush beats everything.
    num_d = '0;
    for (int e = 0; e < int'(BUFF_SIZE); e++) begin
      valid_d[e] = valid_q[e] && !inv_match[e] && !retire[e];
      cnt_d[e]   = cnt_upd[e];
      if (wr_en && wr_sel[e]) begin
        valid_d[e] = 1'b1;
        cnt_d[e]   = '0;
      end
      if (bus.flush) begin
        valid_d[e] = 1'b0;
      end
      num_d = num_d + NumW'(valid_d[e]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      ptr_q   <= '0;
      num_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      evict_q <= 1'b0;
      for (int e = 0; e < int'(BUFF_SIZE); e++) begin
        cnt_q[e] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      full_q  <= (num_d == NumW'(BUFF_SIZE));
      empty_q <= (num_d == '0);
      evict_q <= evict_d;
      for (int e = 0; e < int'(BUFF_SIZE); e++) begin
        cnt_q[e] <= cnt_d[e];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int e = 0; e < int'(BUFF_SIZE); e++) begin
      if (reset && wr_en && wr_sel[e]) begin
        idx_q[e]  <= bus.wb_index;
        data_q[e] <= bus.wb_data;
      end
    end
  end

  assign bus.src_data = src_data;
  assign bus.src_hit  = hit;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.num      = num_q;
  assign bus.evict    = evict_q;
endmodule

// File: tb/tb_bypass_buff_mp.sv
// Bench for bypass_buff_mp: one instance without retirement, one with REUSE_MAX=2, both checked
// every cycle against an entry-list reference model, plus directed table rows and sequences.
module tb_bypass_buff_mp;
  localparam logic [95:0] RF = {32'h333, 32'h222, 32'h111};

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  bypass_buff_mp_if #(.BUFF_SIZE(8), .NUM_SRC(3), .WIDTH_IDX(8), .WIDTH_DATA(32)) bus_a ();
  bypass_buff_mp_if #(.BUFF_SIZE(8), .NUM_SRC(3), .WIDTH_IDX(8), .WIDTH_DATA(32)) bus_b ();

  assign bus_b.stall       = bus_a.stall;
  assign bus_b.flush       = bus_a.flush;
  assign bus_b.inv_valid   = bus_a.inv_valid;
  assign bus_b.inv_index   = bus_a.inv_index;
  assign bus_b.wb_valid    = bus_a.wb_valid;
  assign bus_b.wb_index    = bus_a.wb_index;
  assign bus_b.wb_data     = bus_a.wb_data;
  assign bus_b.src_valid   = bus_a.src_valid;
  assign bus_b.src_index   = bus_a.src_index;
  assign bus_b.src_rf_data = bus_a.src_rf_data;

  bypass_buff_mp #(
    .BUFF_SIZE(8), .NUM_SRC(3), .WIDTH_IDX(8), .WIDTH_DATA(32), .REUSE_MAX(0), .FWD_WB(1)
  ) dut_a (
    .clock(clock),
    .reset(rst_n),
    .bus  (bus_a)
  );

  bypass_buff_mp #(
    .BUFF_SIZE(8), .NUM_SRC(3), .WIDTH_IDX(8), .WIDTH_DATA(32), .REUSE_MAX(2), .FWD_WB(1)
  ) dut_b (
    .clock(clock),
    .reset(rst_n),
    .bus  (bus_b)
  );

  // Reference model: k=0 mirrors dut_a (no retirement), k=1 mirrors dut_b (REUSE_MAX=2).
  bit          mv  [2][8];
  logic [7:0]  mi  [2][8];
  logic [31:0] md  [2][8];
  int          mc  [2][8];
  int          mp  [2];
  bit          mev [2];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          flush;
    bit          inv_v;
    logic [7:0]  inv_i;
    bit          wb_v;
    logic [7:0]  wb_i;
    logic [31:0] wb_d;
    logic [2:0]  sv;
    logic [23:0] si;
    logic [2:0]  eh;
    logic [95:0] ed;
    int          en;
    bit          ef;
    bit          ee;
    bit          eev;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    logic [2:0]  ah;
    logic [95:0] ad;
    logic [3:0]  an;
    logic        af, ae, aev;
    logic [7:0]  ix;
    logic        eh;
    logic [31:0] ed;
    int          cnt;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        ah = bus_a.src_hit; ad = bus_a.src_data; an = bus_a.num;
        af = bus_a.full;    ae = bus_a.empty;    aev = bus_a.evict;
      end else begin
        ah = bus_b.src_hit; ad = bus_b.src_data; an = bus_b.num;
        af = bus_b.full;    ae = bus_b.empty;    aev = bus_b.evict;
      end
      cnt = 0;
      for (int e = 0; e < 8; e++) if (mv[k][e]) cnt++;
      for (int p = 0; p < 3; p++) begin
        ix = bus_a.src_index[p*8 +: 8];
        eh = 1'b0;
        ed = bus_a.src_rf_data[p*32 +: 32];
        if (bus_a.src_valid[p]) begin
          if (bus_a.wb_valid && bus_a.wb_index == ix) begin
            eh = 1'b1;
            ed = bus_a.wb_data;
          end else begin
            for (int e = 0; e < 8; e++) begin
              if (mv[k][e] && mi[k][e] == ix) begin
                eh = 1'b1;
                ed = md[k][e];
              end
            end
          end
        end
        chk($sformatf("model inst%0d port%0d hit", k, p), 128'(ah[p]), 128'(eh));
        chk($sformatf("model inst%0d port%0d data", k, p), 128'(ad[p*32 +: 32]), 128'(ed));
      end
      chk($sformatf("model inst%0d num", k), 128'(an), 128'(cnt));
      chk($sformatf("model inst%0d full", k), 128'(af), 128'(cnt == 8));
      chk($sformatf("model inst%0d empty", k), 128'(ae), 128'(cnt == 0));
      chk($sformatf("model inst%0d evict", k), 128'(aev), 128'(mev[k]));
    end
  endtask

  task automatic model_step(input int k, input int rmax);
    bit         ov   [8];
    int         hits [8];
    bit         kill [8];
    int         tgt;
    logic [7:0] ix;
    if (!rst_n) begin
      for (int e = 0; e < 8; e++) begin
        mv[k][e] = 1'b0;
        mc[k][e] = 0;
      end
      mp[k]  = 0;
      mev[k] = 1'b0;
      return;
    end
    for (int e = 0; e < 8; e++) begin
      ov[e]   = mv[k][e];
      hits[e] = 0;
      kill[e] = 1'b0;
    end
    for (int p = 0; p < 3; p++) begin
      ix = bus_a.src_index[p*8 +: 8];
      if (bus_a.src_valid[p] && !(bus_a.wb_valid && bus_a.wb_index == ix)) begin
        for (int e = 0; e < 8; e++) if (ov[e] && mi[k][e] == ix) hits[e]++;
      end
    end
    if (rmax > 0 && !bus_a.stall) begin
      for (int e = 0; e < 8; e++) begin
        if (hits[e] > 0) begin
          mc[k][e] = (mc[k][e] + hits[e] >= rmax) ? rmax : mc[k][e] + hits[e];
          kill[e]  = (mc[k][e] == rmax);
        end
      end
    end
    if (bus_a.inv_valid) begin
      for (int e = 0; e < 8; e++) if (ov[e] && mi[k][e] == bus_a.inv_index) kill[e] = 1'b1;
    end
    for (int e = 0; e < 8; e++) if (kill[e]) mv[k][e] = 1'b0;
    mev[k] = 1'b0;
    if (bus_a.wb_valid && !bus_a.flush) begin
      tgt = -1;
      for (int e = 0; e < 8; e++) if (ov[e] && mi[k][e] == bus_a.wb_index) tgt = e;
      if (tgt < 0) begin
        for (int e = 7; e >= 0; e--) if (!ov[e]) tgt = e;
      end
      if (tgt < 0) begin
        tgt    = mp[k];
        mp[k]  = (mp[k] + 1) % 8;
        mev[k] = 1'b1;
      end
      mv[k][tgt] = 1'b1;
      mi[k][tgt] = bus_a.wb_index;
      md[k][tgt] = bus_a.wb_data;
      mc[k][tgt] = 0;
    end
    if (bus_a.flush) begin
      for (int e = 0; e < 8; e++) mv[k][e] = 1'b0;
    end
  endtask

  task automatic idle();
    rst_n             = 1'b1;
    bus_a.stall       = 1'b0;
    bus_a.flush       = 1'b0;
    bus_a.inv_valid   = 1'b0;
    bus_a.inv_index   = '0;
    bus_a.wb_valid    = 1'b0;
    bus_a.wb_index    = '0;
    bus_a.wb_data     = '0;
    bus_a.src_valid   = '0;
    bus_a.src_index   = '0;
    bus_a.src_rf_data = RF;
  endtask

  task automatic wb(input logic [7:0] i, input logic [31:0] d);
    bus_a.wb_valid = 1'b1;
    bus_a.wb_index = i;
    bus_a.wb_data  = d;
  endtask

  task automatic src(input int p, input logic [7:0] i);
    bus_a.src_valid[p]        = 1'b1;
    bus_a.src_index[p*8 +: 8] = i;
  endtask

  task automatic sample();
    @(negedge clock);
    model_check();
  endtask

  task automatic commit();
    model_step(0, 0);
    model_step(1, 2);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // flush, inv_v, inv_i, wb_v, wb_i, wb_d, sv, si{2,1,0}, eh, ed{2,1,0}, en, ef, ee, eev
    tbl.push_back('{0, 0, 8'd0, 1, 8'd5, 32'hA5, 3'b000, 24'h000000,
                    3'b000, RF, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 8'd0, 0, 8'd0, 32'h0, 3'b011, 24'h000605,
                    3'b001, {32'h333, 32'h222, 32'hA5}, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 8'd0, 1, 8'd9, 32'h99, 3'b100, 24'h090000,
                    3'b100, {32'h99, 32'h222, 32'h111}, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 8'd0, 1, 8'd9, 32'h77, 3'b000, 24'h000000,
                    3'b000, RF, 2, 0, 0, 0});
    tbl.push_back('{0, 0, 8'd0, 0, 8'd0, 32'h0, 3'b100, 24'h090000,
                    3'b100, {32'h77, 32'h222, 32'h111}, 2, 0, 0, 0});
    tbl.push_back('{0, 1, 8'd4, 1, 8'd4, 32'h44, 3'b000, 24'h000000,
                    3'b000, RF, 2, 0, 0, 0});
    tbl.push_back('{0, 0, 8'd0, 0, 8'd0, 32'h0, 3'b001, 24'h000004,
                    3'b001, {32'h333, 32'h222, 32'h44}, 3, 0, 0, 0});
    tbl.push_back('{1, 0, 8'd0, 1, 8'd7, 32'h70, 3'b000, 24'h000000,
                    3'b000, RF, 3, 0, 0, 0});
    tbl.push_back('{0, 0, 8'd0, 0, 8'd0, 32'h0, 3'b001, 24'h000007,
                    3'b000, RF, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 8'd7, 0, 8'd0, 32'h0, 3'b111, 24'h090504,
                    3'b000, RF, 0, 0, 1, 0});

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_step(0, 0);
    model_step(1, 2);
    idle();

    for (int t = 0; t < tbl.size(); t++) begin
      idle();
      bus_a.flush     = tbl[t].flush;
      bus_a.inv_valid = tbl[t].inv_v;
      bus_a.inv_index = tbl[t].inv_i;
      bus_a.wb_valid  = tbl[t].wb_v;
      bus_a.wb_index  = tbl[t].wb_i;
      bus_a.wb_data   = tbl[t].wb_d;
      bus_a.src_valid = tbl[t].sv;
      bus_a.src_index = tbl[t].si;
      sample();
      chk($sformatf("vec%0d hit", t), 128'(bus_a.src_hit), 128'(tbl[t].eh));
      chk($sformatf("vec%0d data", t), 128'(bus_a.src_data), 128'(tbl[t].ed));
      chk($sformatf("vec%0d num", t), 128'(bus_a.num), 128'(tbl[t].en));
      chk($sformatf("vec%0d full", t), 128'(bus_a.full), 128'(tbl[t].ef));
      chk($sformatf("vec%0d empty", t), 128'(bus_a.empty), 128'(tbl[t].ee));
      chk($sformatf("vec%0d evict", t), 128'(bus_a.evict), 128'(tbl[t].eev));
      commit();
    end

    // Nine distinct writes into eight entries: entry 0 (idx 0) is evicted.
    idle(); bus_a.flush = 1'b1; sample(); commit();
    for (int i = 0; i < 9; i++) begin
      idle(); wb(8'(i), 32'h100 + i); sample(); commit();
    end
    idle(); src(0, 8'd0); src(1, 8'd8); sample();
    chk("evict pulse", 128'(bus_a.evict), 128'(1));
    chk("evict full", 128'(bus_a.full), 128'(1));
    chk("evict num", 128'(bus_a.num), 128'(8));
    chk("evict idx0 hit", 128'(bus_a.src_hit[0]), 128'(0));
    chk("evict idx0 data", 128'(bus_a.src_data[31:0]), 128'(32'h111));
    chk("evict idx8 hit", 128'(bus_a.src_hit[1]), 128'(1));
    chk("evict idx8 data", 128'(bus_a.src_data[63:32]), 128'(32'h108));
    commit();
    idle(); sample(); chk("evict one cycle", 128'(bus_a.evict), 128'(0)); commit();

    // Mid-operation reset with five entries; eviction pointer must restart at entry 0.
    idle(); bus_a.flush = 1'b1; sample(); commit();
    for (int i = 0; i < 5; i++) begin
      idle(); wb(8'(20 + i), 32'h200 + i); sample(); commit();
    end
    idle(); sample(); chk("pre-reset num", 128'(bus_a.num), 128'(5)); commit();
    idle(); rst_n = 1'b0; sample(); commit();
    idle(); src(0, 8'd20); src(1, 8'd21); src(2, 8'd24); sample();
    chk("reset num", 128'(bus_a.num), 128'(0));
    chk("reset empty", 128'(bus_a.empty), 128'(1));
    chk("reset hits", 128'(bus_a.src_hit), 128'(0));
    chk("reset data", 128'(bus_a.src_data), 128'(RF));
    commit();
    for (int i = 0; i < 9; i++) begin
      idle(); wb(8'(30 + i), 32'h300 + i); sample(); commit();
    end
    idle(); src(0, 8'd30); src(1, 8'd31); sample();
    chk("ptr restart idx30 hit", 128'(bus_a.src_hit[0]), 128'(0));
    chk("ptr restart idx31 hit", 128'(bus_a.src_hit[1]), 128'(1));
    chk("ptr restart idx31 data", 128'(bus_a.src_data[63:32]), 128'(32'h301));
    chk("ptr restart evict", 128'(bus_a.evict), 128'(1));
    commit();

    // Retirement on the REUSE_MAX=2 instance, then the same under stall.
    idle(); bus_a.flush = 1'b1; sample(); commit();
    idle(); wb(8'd3, 32'h33); sample(); commit();
    idle(); src(0, 8'd3); src(1, 8'd3); sample();
    chk("retire both hit", 128'(bus_b.src_hit), 128'(3'b011));
    chk("retire data", 128'(bus_b.src_data[63:0]), 128'({32'h33, 32'h33}));
    commit();
    idle(); src(0, 8'd3); sample();
    chk("retired miss", 128'(bus_b.src_hit[0]), 128'(0));
    chk("retired num", 128'(bus_b.num), 128'(0));
    chk("retired empty", 128'(bus_b.empty), 128'(1));
    chk("no-retire inst hit", 128'(bus_a.src_hit[0]), 128'(1));
    commit();
    idle(); wb(8'd3, 32'h34); sample(); commit();
    idle(); bus_a.stall = 1'b1; src(0, 8'd3); src(1, 8'd3); sample();
    chk("stall both hit", 128'(bus_b.src_hit), 128'(3'b011));
    commit();
    idle(); bus_a.stall = 1'b1; src(0, 8'd3); sample();
    chk("stall persists hit", 128'(bus_b.src_hit[0]), 128'(1));
    chk("stall persists data", 128'(bus_b.src_data[31:0]), 128'(32'h34));
    chk("stall persists num", 128'(bus_b.num), 128'(1));
    commit();

    // Randomised traffic over a small index space so hits, evictions and retirements collide.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst_n           = ($urandom_range(0, 63) != 0);
      bus_a.stall     = ($urandom_range(0, 3) == 0);
      bus_a.flush     = ($urandom_range(0, 31) == 0);
      bus_a.inv_valid = ($urandom_range(0, 3) == 0);
      bus_a.inv_index = 8'($urandom_range(0, 11));
      bus_a.wb_valid  = rst_n && ($urandom_range(0, 1) == 1);
      bus_a.wb_index  = 8'($urandom_range(0, 11));
      bus_a.wb_data   = $urandom;
      bus_a.src_valid = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) begin
        bus_a.src_index[p*8 +: 8]    = 8'($urandom_range(0, 11));
        bus_a.src_rf_data[p*32 +: 32] = $urandom;
      end
      sample();
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bypass_buff_mp.md
Name: bypass_buff_mp

Overview:
- Parametrised successor of the TPU back-end bypass buffer.
- Fully-associative store of recent write-back results, looked up by NUM_SRC source ports in the same cycle.
- Adds in-place update of a re-written index, same-cycle write-back forwarding, per-entry reuse-count retirement, selective invalidate, flush, and round-robin eviction when full.
- Sits between the register-file read stage and the execute stage.

Parameters:
- BUFF_SIZE, 8: number of entries (>=2).
- NUM_SRC, 3: number of source lookup ports (>=1).
- WIDTH_IDX, 8: register index width.
- WIDTH_DATA, 32: data width.
- REUSE_MAX, 0: hits before an entry auto-retires; 0 disables retirement.
- FWD_WB, 1: 1 enables same-cycle write-back to source forwarding.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- I_Stall  in  1  freezes hit accounting.
- I_Flush  in  1  invalidates all entries.
- I_Inv_Valid  in  1  selective invalidate request.
- I_Inv_Index  in  WIDTH_IDX  index to invalidate.
- I_WB_Valid  in  1  write-back strobe.
- I_WB_Index  in  WIDTH_IDX  write-back index.
- I_WB_Data  in  WIDTH_DATA  write-back data.
- I_Src_Valid  in  NUM_SRC  per-port lookup valid.
- I_Src_Index  in  NUM_SRC*WIDTH_IDX  per-port index; port p occupies slice p.
- I_Src_Data  in  NUM_SRC*WIDTH_DATA  register-file data; passed through on miss.
- O_Src_Data  out  NUM_SRC*WIDTH_DATA  selected data per port.
- O_Src_Hit  out  NUM_SRC  per-port hit flag.
- O_Full  out  1  all entries valid (registered).
- O_Empty  out  1  no entry valid (registered).
- O_Num  out  $clog2(BUFF_SIZE+1)  valid entry count (registered).
- O_Evict  out  1  one-cycle pulse: the previous cycle's write evicted a valid entry.

Behaviour:
- Reset (reset==0 at a clock edge): all valid bits, use counters and the eviction pointer clear to 0. Outputs become O_Full=0, O_Empty=1, O_Num=0, O_Evict=0, O_Src_Hit=0, O_Src_Data=I_Src_Data. A reset mid-operation drops all content; any write in that cycle is discarded.
- Lookup, combinational, zero latency. Port p hits when I_Src_Valid[p]=1 and some valid entry's index equals the port index.
  - FWD_WB=1 and I_WB_Valid with I_WB_Index equal to the port index: O_Src_Data = I_WB_Data and hit=1. This has priority over a stored entry.
  - On a miss, O_Src_Data = I_Src_Data.
  - An index is held in at most one entry, so the match is one-hot.
- Write:
  - Index already present: overwrite the data in place and reset that entry's use counter to 0. No allocation.
  - Otherwise: allocate the lowest-numbered free entry.
  - If full: overwrite the entry at the eviction pointer, advance the pointer modulo BUFF_SIZE, and assert O_Evict in the next cycle.
- Reuse retirement (REUSE_MAX>0, I_Stall=0):
  - Each port hit on a stored entry adds 1 to that entry's counter. k ports hitting the same entry add k.
  - Counter saturates at REUSE_MAX.
  - When the updated count reaches REUSE_MAX, the entry's valid bit clears at the clock edge. The hits in that cycle still return the data.
  - Forwarded hits (from the write-back path) do not count.
- I_Stall=1: lookups still return data; counters do not change. Writes, flush and invalidate still act.
- Same-cycle priority, highest first: reset > flush > write > invalidate/retirement.
  - A flush discards a write in the same cycle.
  - A write to an index that is also being invalidated or retired leaves a valid entry with the new data and counter 0.
- Invalidate on an index that is not present: no effect.
- O_Num, O_Full and O_Empty reflect state after the clock edge. They are consistent by construction: O_Full = (O_Num==BUFF_SIZE), O_Empty = (O_Num==0).

Test Plan:
- Write idx 5 = 0xA5, then next cycle read src0 idx 5 with I_Src_Data=0x11 -> O_Src_Hit[0]=1, data 0xA5. src1 idx 6 -> hit 0, data passthrough; O_Num=1.
- FWD_WB=1: write idx 9 = 0x99 while src2 reads idx 9 in the same cycle -> hit=1, data 0x99. Then write idx 9 = 0x77 -> O_Num stays 1, a subsequent read returns 0x77.
- BUFF_SIZE=8: write 9 distinct indices 0..8 -> after the 9th write O_Evict=1 for one cycle, idx 0 misses, idx 8 hits, O_Full=1.
- REUSE_MAX=2: write idx 3, then one cycle with src0 and src1 both reading idx 3 -> both hit that cycle, next cycle idx 3 misses, O_Num=0. Repeat with I_Stall=1 -> entry persists.
- Invalidate idx 4 and write idx 4 = 0x44 in the same cycle -> entry valid with data 0x44. Flush and write idx 7 in the same cycle -> O_Empty=1, idx 7 misses.
- Assert reset=0 for one cycle with 5 valid entries -> O_Num=0, O_Empty=1, all ports miss; the eviction pointer restarts at entry 0.
